// File: rtl/decode_stage_if.sv
// Fetch/execute-facing bus of decode_stage: fetch handshake in, decoded fields out.
// master = environment (fetch + execute), slave = the decode stage.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_ready;
    logic            out_valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [XLEN-1:0] out_pc;
    logic            stall;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, rs1, rs2, rd, opcode, func3, func7,
               imm, fmt, illegal, out_pc, stall
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, rs1, rs2, rd, opcode, func3, func7,
               imm, fmt, illegal, out_pc, stall
    );
endinterface

// File: rtl/decode_stage.sv
// RV32 decode stage: format classification, immediate generation and a RAW tracker that inserts bubbles.
// Define DECODE_FORWARDING_EN to stall only on load-use (entry 0); default is full interlock.
module decode_stage #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = XLEN'(32'h0040_0000),
    parameter int              HAZARD_DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    decode_stage_if.slave bus
);

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } dec_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } trk_t;

    dec_t                     out_q, out_d;
    logic                     out_valid_q;
    logic [XLEN-1:0]          out_pc_q;
    trk_t [HAZARD_DEPTH-1:0]  trk_q;
    trk_t                     trk_d;

    logic [31:0] instr;
    logic [6:0]  opc;
    logic [4:0]  src1, src2, dst;
    fmt_e        fmt;
    logic        is_load;
    logic [31:0] imm32;
    logic        uses_rs1, uses_rs2, writes;
    logic        hazard_src, hazard, advance, accept;
    dec_t        dec;

    assign instr = bus.in_instr;
    assign opc   = instr[6:0];
    assign src1  = instr[19:15];
    assign src2  = instr[24:20];
    assign dst   = instr[11:7];

    // NOTE: every signal written in an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        fmt     = FMT_NONE;
        is_load = 1'b0;
        case (opc)
            7'b0110011:                         fmt = FMT_R;
            7'b0010011, 7'b1100111:             fmt = FMT_I;
            7'b0000011: begin                   fmt = FMT_I; is_load = 1'b1; end
            7'b0100011:                         fmt = FMT_S;
            7'b1100011:                         fmt = FMT_B;
            7'b0110111, 7'b0010111:             fmt = FMT_U;
            7'b1101111:                         fmt = FMT_J;
            default:                            fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign uses_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    assign uses_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};
    assign writes   = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (dst != 5'd0);

    function automatic logic reads_reg(input logic [4:0] r);
        return (uses_rs1 && src1 != 5'd0 && src1 == r) ||
               (uses_rs2 && src2 != 5'd0 && src2 == r);
    endfunction

    always_comb begin
        hazard_src = 1'b0;
`ifdef DECODE_FORWARDING_EN
        // ALU results are forwarded; only a load in the newest slot cannot be.
        if (trk_q[0].valid && trk_q[0].is_load && reads_reg(trk_q[0].rd))
            hazard_src = 1'b1;
`else
        for (int i = 0; i < HAZARD_DEPTH; i++) begin
            if (trk_q[i].valid && reads_reg(trk_q[i].rd))
                hazard_src = 1'b1;
        end
`endif
    end

    assign hazard  = bus.in_valid & hazard_src;
    assign advance = !out_valid_q | bus.out_ready;
    assign accept  = bus.in_valid & bus.in_ready;

    assign bus.in_ready = !flush & advance & !hazard;
    assign bus.stall    = bus.in_valid & advance & hazard;

    always_comb begin
        dec         = '0;
        dec.rs1     = src1;
        dec.rs2     = src2;
        dec.rd      = dst;
        dec.opcode  = opc;
        dec.func3   = instr[14:12];
        dec.func7   = instr[31:25];
        dec.imm     = XLEN'($signed(imm32));
        dec.fmt     = fmt;
        dec.illegal = (fmt == FMT_NONE);

        out_d = accept ? dec : '0;

        trk_d         = '0;
        trk_d.valid   = accept & writes;
        trk_d.rd      = dst;
        trk_d.is_load = is_load;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_pc_q    <= RESET_PC;
            // NOTE: the tracker is reset like any control state; stale entries would raise false hazards.
            trk_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_pc_q    <= '0;
            trk_q       <= '0;
        end else if (advance) begin
            out_valid_q <= accept;
            out_q       <= out_d;
            if (accept)
                out_pc_q <= bus.in_pc;
            for (int i = HAZARD_DEPTH - 1; i > 0; i--)
                trk_q[i] <= trk_q[i-1];
            trk_q[0] <= trk_d;
        end
    end

    // Entries the active hazard mode never reads still shift; sink them here.
    logic unused_trk;
    assign unused_trk = ^trk_q;

    assign bus.out_valid = out_valid_q;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.rd        = out_q.rd;
    assign bus.opcode    = out_q.opcode;
    assign bus.func3     = out_q.func3;
    assign bus.func7     = out_q.func7;
    assign bus.imm       = out_q.imm;
    assign bus.fmt       = out_q.fmt;
    assign bus.illegal   = out_q.illegal;
    assign bus.out_pc    = out_pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: immediates, formats, load-use interlock, back-pressure, flush, async reset.
module tb_decode_stage;
    localparam int XLEN = 32;
    localparam int HD   = 2;
`ifdef DECODE_FORWARDING_EN
    localparam int LOAD_USE_BUBBLES = 1;
    localparam int OLD_ALU_STALL    = 0;
`else
    localparam int LOAD_USE_BUBBLES = 2;
    localparam int OLD_ALU_STALL    = 1;
`endif

    localparam logic [31:0] ADDI_X5  = 32'hFFF0_0293;
    localparam logic [31:0] BEQ_M4   = 32'hFE00_0EE3;
    localparam logic [31:0] JAL_X1   = 32'hFF9F_F0EF;
    localparam logic [31:0] ILL_RD6  = 32'h0000_037F;
    localparam logic [31:0] LW_X6    = 32'h0002_A303;
    localparam logic [31:0] ADD_X7   = 32'h0063_03B3;
    localparam logic [31:0] ADDI_X0  = 32'h0010_0013;
    localparam logic [31:0] ADD_X8   = 32'h0000_0433;
    localparam logic [31:0] ADD_X9   = 32'h0020_84B3;
    localparam logic [31:0] ADD_X10  = 32'h0002_8533;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    int   bubbles;

    always #5 clock = ~clock;

    decode_stage_if #(.XLEN(XLEN)) bus ();

    decode_stage #(
        .XLEN         (XLEN),
        .RESET_PC     (32'h0040_0000),
        .HAZARD_DEPTH (HD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] instr, input logic [XLEN-1:0] pc);
        bus.in_valid = v;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b1;
        repeat (2) tick();

        check("rst_valid",   bus.out_valid, 0);
        check("rst_pc",      bus.out_pc, 32'h0040_0000);
        check("rst_imm",     bus.imm, 0);
        check("rst_rd",      bus.rd, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_stall",   bus.stall, 0);
        reset = 1'b0;

        // Format and immediate decode, one per cycle
        present(1, ADDI_X5, 32'h100);
        check("addi_ready", bus.in_ready, 1);
        tick();
        check("addi_valid", bus.out_valid, 1);
        check("addi_fmt",   bus.fmt, 1);
        check("addi_rd",    bus.rd, 5);
        check("addi_imm",   bus.imm, 32'hFFFF_FFFF);
        check("addi_op",    bus.opcode, 7'h13);
        check("addi_pc",    bus.out_pc, 32'h100);

        present(1, BEQ_M4, 32'h104);
        check("beq_ready", bus.in_ready, 1);
        tick();
        check("beq_fmt", bus.fmt, 3);
        check("beq_imm", bus.imm, 32'hFFFF_FFFC);

        present(1, JAL_X1, 32'h108);
        tick();
        check("jal_fmt", bus.fmt, 5);
        check("jal_rd",  bus.rd, 1);
        check("jal_imm", bus.imm, 32'hFFFF_FFF8);

        present(1, ILL_RD6, 32'h10C);
        tick();
        check("ill_flag", bus.illegal, 1);
        check("ill_fmt",  bus.fmt, 7);
        check("ill_imm",  bus.imm, 0);

        // Illegal op with rd field x6 must not block a reader of x6
        present(1, ADD_X7, 32'h110);
        check("ill_notrk_ready", bus.in_ready, 1);
        check("ill_notrk_stall", bus.stall, 0);
        tick();
        check("add_fmt",   bus.fmt, 0);
        check("add_rd",    bus.rd, 7);
        check("add_rs1",   bus.rs1, 6);
        check("add_rs2",   bus.rs2, 6);
        check("add_f7",    bus.func7, 0);

        present(1, ADDI_X0, 32'h114);
        tick();
        present(1, ADD_X8, 32'h118);
        check("x0_ready", bus.in_ready, 1);
        tick();
        check("x0_rd", bus.rd, 8);

        present(0, 32'h0, 32'h0);
        tick();
        check("bubble_valid", bus.out_valid, 0);
        check("bubble_pc",    bus.out_pc, 32'h118);
        check("bubble_imm",   bus.imm, 0);
        tick();

        // Load-use interlock
        present(1, LW_X6, 32'h200);
        tick();
        check("lw_rd", bus.rd, 6);
        present(1, ADD_X7, 32'h204);
        bubbles = 0;
        while (!bus.in_ready && bubbles < 6) begin
            check("lu_stall", bus.stall, 1);
            tick();
            check("lu_bubble", bus.out_valid, 0);
            bubbles++;
        end
        check("lu_count", bubbles, LOAD_USE_BUBBLES);
        tick();
        check("lu_valid", bus.out_valid, 1);
        check("lu_rd",    bus.rd, 7);
        check("lu_pc",    bus.out_pc, 32'h204);

        // Back-pressure: everything holds while execute is not ready
        present(1, ADDI_X5, 32'h300);
        tick();
        bus.out_ready = 1'b0;
        present(1, ADD_X9, 32'h304);
        for (int i = 0; i < 3; i++) begin
            check("hold_ready", bus.in_ready, 0);
            check("hold_stall", bus.stall, 0);
            check("hold_valid", bus.out_valid, 1);
            check("hold_pc",    bus.out_pc, 32'h300);
            check("hold_imm",   bus.imm, 32'hFFFF_FFFF);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("rel_ready", bus.in_ready, 1);
        tick();
        check("rel_valid", bus.out_valid, 1);
        check("rel_rd",    bus.rd, 9);
        check("rel_pc",    bus.out_pc, 32'h304);
        // addi x5 must still sit in the tracker after the hold
        present(1, ADD_X10, 32'h308);
        check("trk_kept", bus.stall, OLD_ALU_STALL);
        present(0, 32'h0, 32'h0);
        repeat (2) tick();

        // Flush with a pending load-use hazard
        present(1, LW_X6, 32'h400);
        tick();
        present(1, ADD_X7, 32'h404);
        check("fl_pre_stall", bus.stall, 1);
        flush = 1'b1;
        #1;
        check("fl_ready", bus.in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_valid", bus.out_valid, 0);
        check("fl_pc",    bus.out_pc, 0);
        check("fl_rd",    bus.rd, 0);
        check("fl_imm",   bus.imm, 0);
        check("fl_ready_after", bus.in_ready, 1);
        check("fl_stall_after", bus.stall, 0);
        tick();
        check("fl_issue_valid", bus.out_valid, 1);
        check("fl_issue_rd",    bus.rd, 7);
        check("fl_issue_pc",    bus.out_pc, 32'h404);

        // Flush wins over a held output register
        bus.out_ready = 1'b0;
        present(0, 32'h0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flhold_valid", bus.out_valid, 0);
        check("flhold_pc",    bus.out_pc, 0);
        bus.out_ready = 1'b1;

        // Asynchronous reset mid-cycle
        present(1, ADDI_X5, 32'h500);
        tick();
        check("ar_pre_valid", bus.out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_valid", bus.out_valid, 0);
        check("ar_pc",    bus.out_pc, 32'h0040_0000);
        check("ar_rd",    bus.rd, 0);
        check("ar_imm",   bus.imm, 0);
        check("ar_fmt",   bus.fmt, 0);
        tick();
        reset = 1'b0;
        present(0, 32'h0, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
